// File: rtl/rc_servo_xy_pkg.sv
// Shared constants and timing helpers for the two-axis RC-servo driver.
package rc_servo_xy_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
    localparam int unsigned TICKS_US         = CLK_FREQ_DEFAULT / 1_000_000;
    localparam int unsigned FRAME            = 20_000 * TICKS_US;
    localparam int unsigned PULSE_MIN        = 1_000 * TICKS_US;
    localparam int unsigned STEP_TICKS       = 4 * TICKS_US;
    localparam int unsigned POS_MAX          = 250;
    localparam int unsigned POS_RESET        = 125;

    // Frame counter and pulse width share this width; 100_000 max width fits.
    localparam int unsigned CNT_W = 20;
    localparam int unsigned POS_W = 8;

    function automatic int unsigned ticks_us(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/rc_servo_channel.sv
// One servo axis: comparator synchronizer, saturating position register and PWM compare.
module rc_servo_channel
    import rc_servo_xy_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = CLK_FREQ_DEFAULT,
    parameter int unsigned POS_LIMIT     = POS_MAX,
    parameter int unsigned POS_INIT      = POS_RESET
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             comp_async_i,
    input  logic [CNT_W-1:0] frame_cnt_i,
    input  logic             frame_end_i,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] W_MIN      = CNT_W'(1_000 * ticks_us(CLK_FREQUENCY));
    localparam logic [CNT_W-1:0] W_STEP     = CNT_W'(4 * ticks_us(CLK_FREQUENCY));
    localparam logic [POS_W-1:0] POS_LIM_V  = POS_W'(POS_LIMIT);
    localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);

    logic             r_sync1;
    logic             r_sync2;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_next;
    logic [CNT_W-1:0] w_width;
    logic             r_pwm;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= comp_async_i;
            r_sync2 <= r_sync1;
        end
    end

    // Step once per frame boundary, saturating at both ends of the range.
    always_comb begin
        w_pos_next = r_pos;
        if (frame_end_i) begin
            if (r_sync2) begin
                if (r_pos < POS_LIM_V) begin
                    w_pos_next = r_pos + 1'b1;
                end
            end else if (r_pos != '0) begin
                w_pos_next = r_pos - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pos <= POS_INIT_V;
        end else begin
            r_pos <= w_pos_next;
        end
    end

    assign w_width = W_MIN + CNT_W'(r_pos) * W_STEP;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (frame_cnt_i < w_width);
        end
    end

    assign pwm_o = r_pwm;

endmodule

// File: rtl/rc_servo_xy.sv
// Two-axis 50 Hz servo driver: shared frame counter feeding two independent channels.
module rc_servo_xy
    import rc_servo_xy_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = CLK_FREQ_DEFAULT,
    parameter int unsigned POS_LIMIT     = POS_MAX,
    parameter int unsigned POS_INIT      = POS_RESET
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic comp_async_x_i,
    input  logic comp_async_y_i,
    output logic pwm_pin_x_o,
    output logic pwm_pin_y_o
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(20_000 * ticks_us(CLK_FREQUENCY) - 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_frame_end;

    assign w_frame_end = (r_frame_cnt == FRAME_LAST);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    rc_servo_channel #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .POS_LIMIT    (POS_LIMIT),
        .POS_INIT     (POS_INIT)
    ) u_chan_x (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .comp_async_i(comp_async_x_i),
        .frame_cnt_i (r_frame_cnt),
        .frame_end_i (w_frame_end),
        .pwm_o       (pwm_pin_x_o)
    );

    rc_servo_channel #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .POS_LIMIT    (POS_LIMIT),
        .POS_INIT     (POS_INIT)
    ) u_chan_y (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .comp_async_i(comp_async_y_i),
        .frame_cnt_i (r_frame_cnt),
        .frame_end_i (w_frame_end),
        .pwm_o       (pwm_pin_y_o)
    );

endmodule

// File: tb/tb_rc_servo_xy.sv
// Directed bench: 1 MHz clock (20_000-cycle frames); DUT a uses a low upper limit and DUT b a
// low start position so both saturation ends are reached within a few frames.
module tb_rc_servo_xy;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int          FRAME  = 20_000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ax = 1'b1, ay = 1'b0, bx = 1'b1, by = 1'b0;
    logic px_a, py_a, px_b, py_b;
    logic [3:0] w_pwm;

    int n_tests = 0;
    int n_fail  = 0;
    int hi [4];
    logic first_v [4];
    logic last_v [4];
    int exp_hi [6][4];
    string nm [4] = '{"ax", "ay", "bx", "by"};

    always #5 clk = ~clk;

    assign w_pwm = {py_b, px_b, py_a, px_a};

    rc_servo_xy #(
        .CLK_FREQUENCY(CLK_HZ),
        .POS_LIMIT    (127),
        .POS_INIT     (125)
    ) u_dut_a (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .comp_async_x_i(ax),
        .comp_async_y_i(ay),
        .pwm_pin_x_o   (px_a),
        .pwm_pin_y_o   (py_a)
    );

    rc_servo_xy #(
        .CLK_FREQUENCY(CLK_HZ),
        .POS_LIMIT    (250),
        .POS_INIT     (1)
    ) u_dut_b (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .comp_async_x_i(bx),
        .comp_async_y_i(by),
        .pwm_pin_x_o   (px_b),
        .pwm_pin_y_o   (py_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Comparator changes per frame, keyed by sample index inside the frame.
    task automatic stim(input int f, input int i);
        if (f == 1 && i == 100)  ay = 1'b1;
        if (f == 1 && i == 5000) bx = 1'b0;
        if (f == 1 && i == 6000) bx = 1'b1;
        if (f == 2 && i == 100) begin
            ay = 1'b0;
            bx = 1'b0;
        end
    endtask

    task automatic measure(input int f, input int n);
        for (int k = 0; k < 4; k++) hi[k] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (w_pwm[k]) hi[k]++;
                if (i == 0) first_v[k] = w_pwm[k];
                last_v[k] = w_pwm[k];
            end
            stim(f, i);
        end
    endtask

    task automatic check_frame(input int f, input bit full);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("f%0d_%s_rise", f, nm[k]), int'(first_v[k]), 1);
            check($sformatf("f%0d_%s_high", f, nm[k]), hi[k], exp_hi[f][k]);
            if (full) check($sformatf("f%0d_%s_end_low", f, nm[k]), int'(last_v[k]), 0);
        end
    endtask

    initial begin
        exp_hi[0] = '{1500, 1500, 1004, 1004};
        exp_hi[1] = '{1504, 1496, 1008, 1000};
        exp_hi[2] = '{1508, 1500, 1012, 1000};
        exp_hi[3] = '{1508, 1496, 1008, 1000};
        exp_hi[4] = '{900, 900, 900, 900};
        exp_hi[5] = '{1500, 1500, 1004, 1004};

        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("rst_%s", nm[k]), int'(w_pwm[k]), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            measure(f, FRAME);
            check_frame(f, 1'b1);
        end

        // Reset partway into a frame while every output is still high.
        measure(4, 900);
        check_frame(4, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("pre_rst_%s", nm[k]), int'(last_v[k]), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("async_rst_%s", nm[k]), int'(w_pwm[k]), 0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("rst_hold_%s", nm[k]), int'(w_pwm[k]), 0);
        rst_n = 1'b1;
        measure(5, 3000);
        check_frame(5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
